// File: rtl/cache_lookup_controller.sv
// Sequencing FSM in front of a set-associative tag memory: lookup, miss fetch,
// tag load into the replacement way, LRU update and completion response.
//
// state  | meaning
// IDLE   | ready for a request
// LOOKUP | tag memory compare on the latched address
// MISS   | line fetch outstanding (MEM_REQ held until MEM_ACK)
// FILL   | tag load and data write into the replacement way
// UPDATE | LRU update on the latched way
// RESP   | one-cycle completion pulse
module cache_lookup_controller #(
  parameter int ADDR_TAG_SIZE   = 4,
  parameter int ADDR_INDEX_SIZE = 3,
  parameter int CHANNEL_SIZE    = 3,
  parameter int OFFSET_SIZE     = 2,
  parameter int STAT_SIZE       = 16
) (
  input  logic                                             CLK,
  input  logic                                             RESET,
  input  logic                                             REQ_VALID,
  input  logic [ADDR_TAG_SIZE+ADDR_INDEX_SIZE+OFFSET_SIZE-1:0] REQ_ADDR,
  output logic                                             REQ_READY,
  output logic                                             RESP_VALID,
  output logic                                             RESP_HIT,
  output logic [CHANNEL_SIZE-1:0]                          RESP_CHANNEL,
  output logic [ADDR_INDEX_SIZE-1:0]                       TAG_ADDR_INDEX,
  output logic [ADDR_TAG_SIZE-1:0]                         TAG_ADDR_TAG,
  output logic                                             TAG_SIG_LRU,
  output logic                                             TAG_SIG_LOAD,
  input  logic                                             TAG_HIT,
  input  logic [CHANNEL_SIZE-1:0]                          TAG_CHANNEL,
  output logic                                             MEM_REQ,
  output logic [ADDR_TAG_SIZE+ADDR_INDEX_SIZE-1:0]         MEM_ADDR,
  input  logic                                             MEM_ACK,
  output logic                                             DATA_WE,
  output logic [CHANNEL_SIZE-1:0]                          DATA_CHANNEL,
  output logic [STAT_SIZE-1:0]                             HIT_COUNT,
  output logic [STAT_SIZE-1:0]                             MISS_COUNT
);

  localparam int ADDR_SIZE = ADDR_TAG_SIZE + ADDR_INDEX_SIZE + OFFSET_SIZE;
  localparam logic [STAT_SIZE-1:0] STAT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_MISS, S_FILL, S_UPDATE, S_RESP
  } state_t;

  state_t                     state;
  logic [ADDR_TAG_SIZE-1:0]   tag_q;
  logic [ADDR_INDEX_SIZE-1:0] index_q;
  logic [CHANNEL_SIZE-1:0]    channel_q;
  logic                       first_hit;

  // The byte offset does not take part in the line lookup.
  logic unused_offset;
  assign unused_offset = ^REQ_ADDR[OFFSET_SIZE-1:0];

  assign REQ_READY      = (state == S_IDLE);
  assign TAG_ADDR_INDEX = index_q;
  assign TAG_ADDR_TAG   = tag_q;
  assign MEM_ADDR       = {tag_q, index_q};

  // Strobes are loaded on the edge entering their state so they are clean
  // register outputs aligned with that state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= S_IDLE;
      tag_q        <= '0;
      index_q      <= '0;
      channel_q    <= '0;
      first_hit    <= 1'b0;
      MEM_REQ      <= 1'b0;
      TAG_SIG_LRU  <= 1'b0;
      TAG_SIG_LOAD <= 1'b0;
      DATA_WE      <= 1'b0;
      DATA_CHANNEL <= '0;
      RESP_VALID   <= 1'b0;
      RESP_HIT     <= 1'b0;
      RESP_CHANNEL <= '0;
      HIT_COUNT    <= '0;
      MISS_COUNT   <= '0;
    end else begin
      TAG_SIG_LRU  <= 1'b0;
      TAG_SIG_LOAD <= 1'b0;
      DATA_WE      <= 1'b0;
      DATA_CHANNEL <= '0;
      RESP_VALID   <= 1'b0;
      RESP_HIT     <= 1'b0;
      RESP_CHANNEL <= '0;
      case (state)
        S_IDLE: begin
          if (REQ_VALID) begin
            tag_q   <= REQ_ADDR[ADDR_SIZE-1 -: ADDR_TAG_SIZE];
            index_q <= REQ_ADDR[OFFSET_SIZE +: ADDR_INDEX_SIZE];
            state   <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          first_hit <= TAG_HIT;
          if (TAG_HIT) begin
            channel_q   <= TAG_CHANNEL;
            TAG_SIG_LRU <= 1'b1;
            state       <= S_UPDATE;
            if (HIT_COUNT != STAT_MAX) HIT_COUNT <= HIT_COUNT + 1'b1;
          end else begin
            MEM_REQ <= 1'b1;
            state   <= S_MISS;
            if (MISS_COUNT != STAT_MAX) MISS_COUNT <= MISS_COUNT + 1'b1;
          end
        end
        S_MISS: begin
          // Address is frozen, so the replacement way seen here is the one
          // the tag memory will use for the load in FILL.
          if (MEM_ACK) begin
            MEM_REQ      <= 1'b0;
            TAG_SIG_LOAD <= 1'b1;
            DATA_WE      <= 1'b1;
            DATA_CHANNEL <= TAG_CHANNEL;
            channel_q    <= TAG_CHANNEL;
            state        <= S_FILL;
          end
        end
        S_FILL: begin
          TAG_SIG_LRU <= 1'b1;
          state       <= S_UPDATE;
        end
        S_UPDATE: begin
          RESP_VALID   <= 1'b1;
          RESP_HIT     <= first_hit;
          RESP_CHANNEL <= channel_q;
          state        <= S_RESP;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_lookup_controller.sv
// Randomized scoreboard bench for cache_lookup_controller with an 8-way tag
// memory environment and a queue-based LRU reference model.
module tb_cache_lookup_controller;
  localparam int T = 4, I = 3, C = 3, O = 2, SW = 6;
  localparam int MAXS = (1 << SW) - 1;

  logic CLK = 0, RESET = 1, REQ_VALID = 0;
  logic [T+I+O-1:0] REQ_ADDR = '0;
  logic REQ_READY, RESP_VALID, RESP_HIT, TAG_SIG_LRU, TAG_SIG_LOAD;
  logic [C-1:0] RESP_CHANNEL, TAG_CHANNEL, DATA_CHANNEL;
  logic [I-1:0] TAG_ADDR_INDEX;
  logic [T-1:0] TAG_ADDR_TAG;
  logic TAG_HIT, MEM_REQ, MEM_ACK, DATA_WE;
  logic [T+I-1:0] MEM_ADDR;
  logic [SW-1:0] HIT_COUNT, MISS_COUNT;

  cache_lookup_controller #(.ADDR_TAG_SIZE(T), .ADDR_INDEX_SIZE(I), .CHANNEL_SIZE(C),
    .OFFSET_SIZE(O), .STAT_SIZE(SW)) dut (
    .CLK(CLK), .RESET(RESET), .REQ_VALID(REQ_VALID), .REQ_ADDR(REQ_ADDR),
    .REQ_READY(REQ_READY), .RESP_VALID(RESP_VALID), .RESP_HIT(RESP_HIT),
    .RESP_CHANNEL(RESP_CHANNEL), .TAG_ADDR_INDEX(TAG_ADDR_INDEX),
    .TAG_ADDR_TAG(TAG_ADDR_TAG), .TAG_SIG_LRU(TAG_SIG_LRU), .TAG_SIG_LOAD(TAG_SIG_LOAD),
    .TAG_HIT(TAG_HIT), .TAG_CHANNEL(TAG_CHANNEL), .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR),
    .MEM_ACK(MEM_ACK), .DATA_WE(DATA_WE), .DATA_CHANNEL(DATA_CHANNEL),
    .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT));

  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout expected=event (cycle %0d)", nm, cyc);
  endtask

  // Tag memory environment, driven only by the DUT strobes.
  logic [T-1:0] env_tag[8][8];
  bit env_val[8][8];
  int env_stamp[8][8];
  int env_time = 0;
  always_comb begin
    bit any_inv;
    int best;
    TAG_HIT = 1'b0;
    TAG_CHANNEL = '0;
    any_inv = 1'b0;
    best = 0;
    for (int w = 0; w < 8; w++)
      if (env_val[TAG_ADDR_INDEX][w] && env_tag[TAG_ADDR_INDEX][w] == TAG_ADDR_TAG) begin
        TAG_HIT = 1'b1;
        TAG_CHANNEL = C'(w);
      end
    if (!TAG_HIT) begin
      for (int w = 0; w < 8; w++)
        if (!env_val[TAG_ADDR_INDEX][w]) begin
          any_inv = 1'b1;
          TAG_CHANNEL = C'(w);
        end
      if (!any_inv) begin
        for (int w = 1; w < 8; w++)
          if (env_stamp[TAG_ADDR_INDEX][w] < env_stamp[TAG_ADDR_INDEX][best]) best = w;
        TAG_CHANNEL = C'(best);
      end
    end
  end
  always @(posedge CLK) begin
    if (TAG_SIG_LOAD) begin
      env_tag[TAG_ADDR_INDEX][TAG_CHANNEL] <= TAG_ADDR_TAG;
      env_val[TAG_ADDR_INDEX][TAG_CHANNEL] <= 1'b1;
    end
    if (TAG_SIG_LRU && TAG_HIT) begin
      env_time <= env_time + 1;
      env_stamp[TAG_ADDR_INDEX][TAG_CHANNEL] <= env_time + 1;
    end
  end

  // Backing memory: random ack delay, spurious acks outside a fetch.
  bit ack_hold = 0, force_ack = 0;
  int ack_cyc = -100;
  initial begin
    int d;
    MEM_ACK = 0;
    forever begin
      @(negedge CLK);
      MEM_ACK = 0;
      if (force_ack) MEM_ACK = 1;
      else if (MEM_REQ) begin
        if (!ack_hold) begin
          d = $urandom_range(0, 3);
          repeat (d) @(negedge CLK);
          if (MEM_REQ && !ack_hold) begin
            MEM_ACK = 1;
            ack_cyc = cyc;
          end
        end
      end else if ($urandom_range(0, 7) == 0) MEM_ACK = 1;
    end
  end

  // Reference model: per-set tag table plus LRU order queue (front = victim).
  logic [T-1:0] ref_tag[8][8];
  bit ref_val[8][8];
  int ref_lru[8][$];
  int exp_hc = 0, exp_mc = 0;
  initial for (int s = 0; s < 8; s++) for (int w = 7; w >= 0; w--) ref_lru[s].push_back(w);

  task automatic ref_access(input int tg, input int ix, output bit hit, output int ch);
    hit = 0;
    ch = 0;
    for (int w = 0; w < 8; w++)
      if (ref_val[ix][w] && ref_tag[ix][w] == T'(tg)) begin
        hit = 1;
        ch = w;
      end
    if (!hit) begin
      ch = ref_lru[ix][0];
      ref_tag[ix][ch] = T'(tg);
      ref_val[ix][ch] = 1;
    end
    for (int k = 0; k < ref_lru[ix].size(); k++)
      if (ref_lru[ix][k] == ch) begin
        ref_lru[ix].delete(k);
        break;
      end
    ref_lru[ix].push_back(ch);
    if (hit) exp_hc = (exp_hc == MAXS) ? MAXS : exp_hc + 1;
    else exp_mc = (exp_mc == MAXS) ? MAXS : exp_mc + 1;
  endtask

  typedef struct {
    bit hit; int ch; int hc; int mc; int c0; int tag; int idx;
  } exp_t;
  exp_t sb[$];

  function automatic logic [T+I+O-1:0] mk(input int tg, input int ix);
    logic [O-1:0] off;
    off = O'($urandom);
    return {T'(tg), I'(ix), off};
  endfunction

  int last_c0 = 0;
  bit last_hold = 0, last_hit = 0;
  task automatic issue(input logic [T+I+O-1:0] a, input bit hold, input bit abort);
    bit hit;
    int ch, w;
    exp_t e;
    w = 0;
    REQ_VALID = 1;
    REQ_ADDR = a;
    while (!REQ_READY && w < 200) begin
      @(negedge CLK);
      w++;
    end
    if (!REQ_READY) begin
      fail_now("accept_wait");
      REQ_VALID = 0;
      last_hold = 0;
      return;
    end
    if (last_hold && last_hit) chk("b2b_spacing", cyc - last_c0, 4);
    if (!abort) begin
      ref_access(int'(a[T+I+O-1 -: T]), int'(a[O +: I]), hit, ch);
      e.hit = hit; e.ch = ch; e.hc = exp_hc; e.mc = exp_mc; e.c0 = cyc;
      e.tag = int'(a[T+I+O-1 -: T]); e.idx = int'(a[O +: I]);
      sb.push_back(e);
      last_hit = hit;
    end
    last_c0 = cyc;
    last_hold = hold;
    @(posedge CLK);
    #1;
    if (!hold) begin
      REQ_VALID = 0;
      REQ_ADDR = (T+I+O)'($urandom);
    end
    @(negedge CLK);
  endtask

  // Monitor: pops the scoreboard on each response, checks strobe hygiene.
  bit mem_req_seen = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        if (MEM_REQ) begin
          mem_req_seen = 1;
          if (sb.size() > 0) chk("mem_addr", MEM_ADDR, (sb[0].tag << I) | sb[0].idx);
        end
        if (TAG_SIG_LRU || TAG_SIG_LOAD || RESP_VALID || MEM_REQ)
          chk("strobe_overlap", 32'(TAG_SIG_LRU) + 32'(TAG_SIG_LOAD) + 32'(RESP_VALID) + 32'(MEM_REQ), 1);
        if (TAG_SIG_LOAD || DATA_WE) chk("data_we_with_load", DATA_WE, TAG_SIG_LOAD);
        if (DATA_WE) chk("data_channel", DATA_CHANNEL, TAG_CHANNEL);
        if (!RESP_VALID && (RESP_HIT || RESP_CHANNEL != 0)) chk("resp_idle_zero", {RESP_HIT, RESP_CHANNEL}, 0);
        if (RESP_VALID) begin
          if (sb.size() == 0) chk("unexpected_resp", RESP_VALID, 0);
          else begin
            e = sb.pop_front();
            chk("resp_hit", RESP_HIT, e.hit);
            chk("resp_channel", RESP_CHANNEL, e.ch);
            chk("hit_count", HIT_COUNT, e.hc);
            chk("miss_count", MISS_COUNT, e.mc);
            chk("mem_req_on_miss_only", mem_req_seen, !e.hit);
            if (e.hit) chk("hit_latency", cyc - e.c0, 3);
            else chk("miss_latency", cyc - ack_cyc, 3);
          end
          mem_req_seen = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    repeat (3) @(negedge CLK);
    RESET = 0;
    @(negedge CLK);
    chk("rst_ready", REQ_READY, 1);
    chk("rst_mem_req", MEM_REQ, 0);
    chk("rst_lru", TAG_SIG_LRU, 0);
    chk("rst_load", TAG_SIG_LOAD, 0);
    chk("rst_data_we", DATA_WE, 0);
    chk("rst_resp", RESP_VALID, 0);
    chk("rst_hits", HIT_COUNT, 0);
    chk("rst_misses", MISS_COUNT, 0);

    // Abort a fetch with reset; a late ack must be ignored.
    ack_hold = 1;
    issue(mk(3, 2), 0, 1);
    w = 0;
    while (!MEM_REQ && w < 20) begin
      @(negedge CLK);
      w++;
    end
    chk("abort_mem_req_up", MEM_REQ, 1);
    RESET = 1;
    @(negedge CLK);
    RESET = 0;
    chk("abort_ready", REQ_READY, 1);
    chk("abort_mem_req_low", MEM_REQ, 0);
    chk("abort_no_resp", RESP_VALID, 0);
    chk("abort_miss_clear", MISS_COUNT, 0);
    force_ack = 1;
    repeat (2) @(negedge CLK);
    force_ack = 0;
    repeat (5) begin
      @(negedge CLK);
      chk("late_ack_ignored", {MEM_REQ, REQ_READY}, 2'b01);
    end
    mem_req_seen = 0;
    ack_hold = 0;

    // Cold miss then repeat hit on tag 6 / index 1.
    issue(mk(6, 1), 0, 0);
    issue(mk(6, 1), 0, 0);

    // Nine more distinct tags into index 1, then revisit the first.
    for (int t = 7; t < 16; t++) issue(mk(t, 1), 0, 0);
    issue(mk(7, 1), 0, 0);

    for (int n = 0; n < 50; n++)
      issue(mk($urandom_range(0, 9), $urandom_range(0, 1)), 1'($urandom), 0);
    REQ_VALID = 0;
    last_hold = 0;

    // Back-to-back hits with REQ_VALID held, driving HIT_COUNT into saturation.
    issue(mk(6, 1), 0, 0);
    for (int n = 0; n < MAXS + 8; n++) issue(mk(6, 1), 1, 0);
    REQ_VALID = 0;
    last_hold = 0;
    issue(mk(12, 5), 0, 0);

    w = 0;
    while (sb.size() > 0 && w < 300) begin
      @(negedge CLK);
      w++;
    end
    if (sb.size() > 0) fail_now("drain");
    repeat (3) @(negedge CLK);
    chk("hit_saturated", HIT_COUNT, MAXS);
    chk("miss_final", MISS_COUNT, exp_mc);
    chk("final_idle", REQ_READY, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
